// File: rtl/p_layer_pkg.sv
// p_layer_pkg: shared width, word type and PRESENT pLayer index functions
package p_layer_pkg;

    localparam int PL_WIDTH = 64;

    typedef logic [PL_WIDTH-1:0] pl_word_t;

    function automatic int pl_fwd_idx(input int i);
        return (i == PL_WIDTH - 1) ? i : (16 * i) % (PL_WIDTH - 1);
    endfunction

    function automatic int pl_inv_idx(input int i);
        return (i == PL_WIDTH - 1) ? i : (4 * i) % (PL_WIDTH - 1);
    endfunction

endpackage

// File: rtl/p_layer_wires.sv
// p_layer_wires: pure-wiring bit permutation, forward P or inverse (INV=1)
module p_layer_wires
    import p_layer_pkg::*;
#(
    parameter bit INV = 1'b0
) (
    input  pl_word_t a,
    output pl_word_t y
);

    for (genvar g = 0; g < PL_WIDTH; g++) begin : g_bit
        assign y[INV ? pl_inv_idx(g) : pl_fwd_idx(g)] = a[g];
    end

endmodule

// File: rtl/p_layer.sv
// p_layer: registered PRESENT pLayer; PLAYER_INV_EN adds the inverse port and P/P^-1 mux
module p_layer
    import p_layer_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             Clock,
    input  logic             reset,
    input  logic             done,
`ifdef PLAYER_INV_EN
    input  logic             inverse,
`endif
    input  logic [WIDTH-1:0] original,
    output logic [WIDTH-1:0] permuted,
    output logic             valid
);

    if (WIDTH != PL_WIDTH) begin : g_bad_width
        $error("p_layer: WIDTH must be 64");
    end

    pl_word_t fwd_w;
    pl_word_t nxt;

    p_layer_wires #(.INV(1'b0)) u_fwd (.a(original), .y(fwd_w));

`ifdef PLAYER_INV_EN
    pl_word_t inv_w;
    p_layer_wires #(.INV(1'b1)) u_inv (.a(original), .y(inv_w));
    assign nxt = inverse ? inv_w : fwd_w;
`else
    assign nxt = fwd_w;
`endif

    // capture the permuted word on done; valid pulses for the cycle after each load
    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            permuted <= '0;
            valid    <= 1'b0;
        end else begin
            valid <= done;
            if (done) permuted <= nxt;
        end
    end

endmodule

// File: tb/tb_p_layer.sv
// tb_p_layer: scoreboard bench for p_layer (inverse checks when PLAYER_INV_EN is defined)
module tb_p_layer;

    logic        Clock = 1'b0;
    logic        reset = 1'b1;
    logic        done = 1'b0;
    logic        inverse = 1'b0;
    logic [63:0] original = '0;
    logic [63:0] permuted;
    logic        valid;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [63:0] q[$];
    logic [63:0] last_out = '0;

    p_layer dut (
        .Clock(Clock),
        .reset(reset),
        .done(done),
`ifdef PLAYER_INV_EN
        .inverse(inverse),
`endif
        .original(original),
        .permuted(permuted),
        .valid(valid)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] fwd(input logic [63:0] x);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 63; i++) r[(16 * i) % 63] = x[i];
        r[63] = x[63];
        return r;
    endfunction

    function automatic logic [63:0] inv(input logic [63:0] x);
        logic [63:0] r;
        r = '0;
        for (int j = 0; j < 63; j++) r[(4 * j) % 63] = x[j];
        r[63] = x[63];
        return r;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic drive(input logic d, input logic [63:0] x, input logic iv, input logic [63:0] e);
        done = d;
        original = x;
        inverse = iv;
        if (d) q.push_back(e);
        @(posedge Clock);
        #1;
        check("valid", {63'b0, valid}, {63'b0, d});
        if (d) begin
            if (q.size() == 0) check("sb_empty", 64'd1, 64'd0);
            else begin
                last_out = q.pop_front();
                check("data", permuted, last_out);
            end
        end else check("hold", permuted, last_out);
    endtask

    logic [63:0] vin[8];
    logic [63:0] vexp[8];

    initial begin
        vin[0] = 64'h0000000000000001; vexp[0] = 64'h0000000000000001;
        vin[1] = 64'h0000000000000002; vexp[1] = 64'h0000000000010000;
        vin[2] = 64'h0000000000000004; vexp[2] = 64'h0000000100000000;
        vin[3] = 64'h0000000000000010; vexp[3] = 64'h0000000000000002;
        vin[4] = 64'h8000000000000000; vexp[4] = 64'h8000000000000000;
        vin[5] = 64'h4000000000000000; vexp[5] = 64'h0000800000000000;
        vin[6] = 64'hFFFFFFFFFFFFFFFF; vexp[6] = 64'hFFFFFFFFFFFFFFFF;
        vin[7] = 64'h0000000000000000; vexp[7] = 64'h0000000000000000;

        repeat (2) @(posedge Clock);
        #1;
        check("rst_data", permuted, 64'd0);
        check("rst_valid", {63'b0, valid}, 64'd0);
        reset = 1'b0;

        for (int k = 0; k < 8; k++) drive(1'b1, vin[k], 1'b0, vexp[k]);

        drive(1'b1, 64'h0000000000000002, 1'b0, 64'h0000000000010000);
        for (int k = 0; k < 5; k++) drive(1'b0, rnd64(), 1'b0, 64'd0);

        #1;
        done = 1'b1;
        original = 64'hFFFFFFFFFFFFFFFF;
        reset = 1'b1;
        #1;
        check("async_rst_data", permuted, 64'd0);
        check("async_rst_valid", {63'b0, valid}, 64'd0);
        @(posedge Clock);
        #1;
        check("rst_done_data", permuted, 64'd0);
        check("rst_done_valid", {63'b0, valid}, 64'd0);
        reset = 1'b0;
        done = 1'b0;
        last_out = '0;
        q.delete();

        for (int k = 0; k < 1000; k++) begin
            logic [63:0] x;
            x = rnd64();
            drive(1'b1, x, 1'b0, fwd(x));
        end

`ifdef PLAYER_INV_EN
        drive(1'b1, 64'h0000000000010000, 1'b1, 64'h0000000000000002);
        for (int k = 0; k < 1000; k++) begin
            logic [63:0] x;
            logic [63:0] p;
            x = rnd64();
            drive(1'b1, x, 1'b0, fwd(x));
            p = permuted;
            drive(1'b1, p, 1'b1, x);
            if (k < 20) begin
                logic [63:0] y;
                y = rnd64();
                drive(1'b1, y, 1'b1, inv(y));
            end
        end
`endif

        drive(1'b0, 64'd0, 1'b0, 64'd0);
        check("sb_drained", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
